// File: rtl/hsclk_sel_fsm_if.sv
// Bus-side signal bundle for the high-speed clock select FSM.
// master: CPU cycle tracker / map registers / clock mux acks (drives inputs).
// slave : the FSM itself (drives switch requests, status and divider select).
//   cyc_valid, vpa, vda, himem, vram_wr : qualified CPU bus cycle
//   hs_en, div_wr, div_in                : map register controls
//   hs_ack, ls_ack                       : asynchronous clock mux acks
//   hs_req, ls_req, hs_selected,
//   dummy_access, div_sel, sw_err        : registered FSM outputs
interface hsclk_sel_fsm_if #(
  parameter int unsigned DIV_W = 2
);
  logic             cyc_valid;
  logic             vpa;
  logic             vda;
  logic             himem;
  logic             vram_wr;
  logic             hs_en;
  logic             div_wr;
  logic [DIV_W-1:0] div_in;
  logic             hs_ack;
  logic             ls_ack;
  logic             hs_req;
  logic             ls_req;
  logic             hs_selected;
  logic             dummy_access;
  logic [DIV_W-1:0] div_sel;
  logic             sw_err;

  modport master (
    output cyc_valid, vpa, vda, himem, vram_wr, hs_en, div_wr, div_in,
           hs_ack, ls_ack,
    input  hs_req, ls_req, hs_selected, dummy_access, div_sel, sw_err
  );

  modport slave (
    input  cyc_valid, vpa, vda, himem, vram_wr, hs_en, div_wr, div_in,
           hs_ack, ls_ack,
    output hs_req, ls_req, hs_selected, dummy_access, div_sel, sw_err
  );
endinterface

// File: rtl/hsclk_sel_fsm.sv
// High-speed CPU clock select state machine.
// Switches the CPU to hsclk after two consecutive opcode fetches from on-board
// memory, and back to the low-speed clock on off-board / video RAM accesses
// once a minimum dwell has elapsed, or immediately when hs_en drops.
// Ports:
//   hsclk : single rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : hsclk_sel_fsm_if slave modport (cycle qualifiers, map controls,
//           mux acks in; switch requests, status, divider select out)
module hsclk_sel_fsm #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned DIV_W          = 2
) (
  input  logic            hsclk,
  input  logic            rst,
  hsclk_sel_fsm_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {LS, TO_HS, HS, TO_LS} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hs_ack_s;
  logic                   ls_ack_s;
  logic                   prev_sync;
  logic [TW-1:0]          tmo_cnt;
  logic [7:0]             hold_cnt;
  logic                   op_cyc;
  logic                   fast;
  logic                   drop_cyc;
  logic                   tmo;
  logic                   set_err;

  assign hs_ack_s = hs_sync[SYNC_STAGES-1];
  assign ls_ack_s = ls_sync[SYNC_STAGES-1];
  assign op_cyc   = bus.cyc_valid & bus.vpa & bus.vda;
  assign fast     = op_cyc & bus.himem & ~bus.vram_wr;
  assign drop_cyc = bus.cyc_valid & (bus.vpa | bus.vda) & (~bus.himem | bus.vram_wr);
  assign tmo      = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Ack is tested before timeout so a coincident ack completes the switch.
  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    case (state)
      LS:    if (bus.hs_en & fast & prev_sync) state_nxt = TO_HS;
      TO_HS: begin
        if (hs_ack_s) state_nxt = HS;
        else if (tmo) begin
          state_nxt = LS;
          set_err   = 1'b1;
        end
      end
      HS:    if (~bus.hs_en | (drop_cyc & (hold_cnt == '0))) state_nxt = TO_LS;
      TO_LS: begin
        if (ls_ack_s) state_nxt = LS;
        else if (tmo) begin
          state_nxt = LS;
          set_err   = 1'b1;
        end
      end
      default: state_nxt = LS;
    endcase
  end

  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      state            <= LS;
      hs_sync          <= '0;
      ls_sync          <= '0;
      prev_sync        <= 1'b0;
      tmo_cnt          <= '0;
      hold_cnt         <= '0;
      bus.hs_req       <= 1'b0;
      bus.ls_req       <= 1'b1;
      bus.hs_selected  <= 1'b0;
      bus.dummy_access <= 1'b0;
      bus.div_sel      <= '0;
      bus.sw_err       <= 1'b0;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], bus.hs_ack};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], bus.ls_ack};

      if (op_cyc) prev_sync <= fast;

      state <= state_nxt;

      if (state_nxt != state)
        tmo_cnt <= '0;
      else if ((state == TO_HS) || (state == TO_LS))
        tmo_cnt <= tmo_cnt + TW'(1);

      if ((state_nxt == HS) && (state != HS))
        hold_cnt <= 8'(HOLD_CYCLES - 1);
      else if ((state == HS) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - 8'd1;

      if (set_err) bus.sw_err <= 1'b1;

      // Qualified on the current state, so a write on the LS->TO_HS edge lands.
      if ((state == LS) && bus.div_wr) bus.div_sel <= bus.div_in;

      // Outputs are registered from the next state so they track it exactly.
      bus.hs_req       <= (state_nxt == TO_HS) || (state_nxt == HS);
      bus.ls_req       <= (state_nxt == TO_LS) || (state_nxt == LS);
      bus.hs_selected  <= (state_nxt == HS);
      bus.dummy_access <= (state != LS) | (bus.himem & bus.cyc_valid);
    end
  end

endmodule

// File: tb/tb_hsclk_sel_fsm.sv
// Directed bench for hsclk_sel_fsm with an expected-output scoreboard.
module tb_hsclk_sel_fsm;

  typedef enum int {S_LS, S_TO_HS, S_HS, S_TO_LS} tst_t;
  typedef struct {
    string      tag;
    logic [6:0] vec;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic hsclk = 1'b0;
  logic rst   = 1'b1;

  always #5 hsclk = ~hsclk;

  hsclk_sel_fsm_if #(.DIV_W(2)) bus ();

  hsclk_sel_fsm #(
    .SYNC_STAGES   (2),
    .HOLD_CYCLES   (8),
    .TIMEOUT_CYCLES(64),
    .DIV_W         (2)
  ) dut (
    .hsclk(hsclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Packed as {sw_err, div_sel[1:0], dummy_access, hs_selected, ls_req, hs_req}
  function automatic logic [6:0] pack(tst_t st, logic dm, logic [1:0] dv, logic er);
    return {er, dv, dm, (st == S_HS), (st == S_LS) || (st == S_TO_LS),
            (st == S_TO_HS) || (st == S_HS)};
  endfunction

  task automatic push(string tag, tst_t st, logic dm, logic [1:0] dv, logic er);
    exp_t e;
    e.tag = tag;
    e.vec = pack(st, dm, dv, er);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [6:0] obs;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
      return;
    end
    e   = sb.pop_front();
    obs = {bus.sw_err, bus.div_sel, bus.dummy_access, bus.hs_selected,
           bus.ls_req, bus.hs_req};
    assert (obs === e.vec) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b {err,div,dummy,hs_sel,ls_req,hs_req}",
             e.tag, obs, e.vec);
    end
  endtask

  task automatic clr_cyc();
    bus.cyc_valid = 1'b0;
    bus.vpa       = 1'b0;
    bus.vda       = 1'b0;
    bus.himem     = 1'b0;
    bus.vram_wr   = 1'b0;
    bus.div_wr    = 1'b0;
  endtask

  task automatic step();
    @(posedge hsclk);
    @(negedge hsclk);
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic idle_chk(string tag, tst_t st, logic dm, logic [1:0] dv, logic er);
    push(tag, st, dm, dv, er);
    step();
    clr_cyc();
    check();
  endtask

  task automatic cyc(string tag, logic cv, logic pa, logic da, logic hm, logic vw,
                     tst_t st, logic dm, logic [1:0] dv, logic er);
    bus.cyc_valid = cv;
    bus.vpa       = pa;
    bus.vda       = da;
    bus.himem     = hm;
    bus.vram_wr   = vw;
    idle_chk(tag, st, dm, dv, er);
  endtask

  initial begin
    clr_cyc();
    bus.hs_en  = 1'b0;
    bus.div_in = 2'b00;
    bus.hs_ack = 1'b0;
    bus.ls_ack = 1'b0;

    #12;
    push("reset_state", S_LS, 1'b0, 2'b00, 1'b0);
    check();
    @(negedge hsclk);
    rst       = 1'b0;
    bus.hs_en = 1'b1;

    // Two fetches from himem start the switch; ack sync takes 3 edges
    cyc("s1_fast1", 1, 1, 1, 1, 0, S_LS,    1, 2'b00, 0);
    cyc("s1_fast2", 1, 1, 1, 1, 0, S_TO_HS, 1, 2'b00, 0);
    bus.hs_ack = 1'b1;
    idle_chk("s1_sync1",  S_TO_HS, 1, 2'b00, 0);
    idle_chk("s1_sync2",  S_TO_HS, 1, 2'b00, 0);
    idle_chk("s1_hs_sel", S_HS,    1, 2'b00, 0);

    // Divider write dropped in HS (dwell 1)
    bus.div_wr = 1'b1;
    bus.div_in = 2'b11;
    idle_chk("s4_div_in_hs", S_HS, 1, 2'b00, 0);

    // Dwell: data cycles at 3 (hold live), no-qualifier at 8, data at 9
    idle(1);
    cyc("s2_dwell3_data",  1, 0, 1, 0, 0, S_HS,    1, 2'b00, 0);
    idle(4);
    cyc("s2_no_vpa_vda",   1, 0, 0, 0, 0, S_HS,    1, 2'b00, 0);
    cyc("s2_dwell9_data",  1, 0, 1, 0, 0, S_TO_LS, 1, 2'b00, 0);
    bus.hs_ack = 1'b0;
    bus.ls_ack = 1'b1;
    idle(2);
    idle_chk("s2_ls_after_ack", S_LS, 1, 2'b00, 0);
    idle_chk("s2_dummy_clear",  S_LS, 0, 2'b00, 0);

    // Divider write taken in LS
    bus.div_wr = 1'b1;
    bus.div_in = 2'b11;
    idle_chk("s4_div_in_ls", S_LS, 0, 2'b11, 0);

    // TO_HS timeout with no ack; div write on the LS->TO_HS edge is kept
    bus.ls_ack = 1'b0;
    cyc("s3_nonfast_fetch", 1, 1, 1, 0, 0, S_LS, 0, 2'b11, 0);
    cyc("s3_fast1",         1, 1, 1, 1, 0, S_LS, 1, 2'b11, 0);
    bus.div_wr = 1'b1;
    bus.div_in = 2'b01;
    cyc("s3_fast2_divwr",   1, 1, 1, 1, 0, S_TO_HS, 1, 2'b01, 0);
    idle(62);
    idle_chk("s3_before_tmo", S_TO_HS, 1, 2'b01, 0);
    idle_chk("s3_timeout",    S_LS,    1, 2'b01, 1);

    // Retry with synchronised ack landing on the timeout cycle
    cyc("s3_retry", 1, 1, 1, 1, 0, S_TO_HS, 1, 2'b01, 1);
    idle(61);
    bus.hs_ack = 1'b1;
    idle(1);
    idle_chk("s3_coincide_pre", S_TO_HS, 1, 2'b01, 1);
    idle_chk("s3_ack_wins",     S_HS,    1, 2'b01, 1);

    // vram write at dwell 7 held off, at dwell 8 drops
    idle(6);
    cyc("s6_vram_hold1",   1, 1, 1, 1, 1, S_HS,    1, 2'b01, 1);
    cyc("s6_vram_expired", 1, 1, 1, 1, 1, S_TO_LS, 1, 2'b01, 1);
    bus.hs_ack = 1'b0;
    idle(62);
    idle_chk("s6_tols_pre_tmo", S_TO_LS, 1, 2'b01, 1);
    idle_chk("s6_tols_timeout", S_LS,    1, 2'b01, 1);

    // hs_en removed during the hold period
    cyc("s6_fast1", 1, 1, 1, 1, 0, S_LS,    1, 2'b01, 1);
    cyc("s6_fast2", 1, 1, 1, 1, 0, S_TO_HS, 1, 2'b01, 1);
    bus.hs_ack = 1'b1;
    idle(2);
    idle_chk("s6_hs_again", S_HS, 1, 2'b01, 1);
    idle_chk("s6_dwell1",   S_HS, 1, 2'b01, 1);
    bus.hs_en = 1'b0;
    idle_chk("s6_hs_en_drop", S_TO_LS, 1, 2'b01, 1);
    bus.hs_ack = 1'b0;
    bus.ls_ack = 1'b1;
    idle(2);
    idle_chk("s6_back_ls", S_LS, 1, 2'b01, 1);

    // Asynchronous reset mid-switch, then a lone fast cycle must not switch
    bus.ls_ack = 1'b0;
    bus.hs_en  = 1'b1;
    cyc("s5_fast", 1, 1, 1, 1, 0, S_TO_HS, 1, 2'b01, 1);
    #2 rst = 1'b1;
    #1;
    push("s5_async_rst", S_LS, 0, 2'b00, 0);
    check();
    @(negedge hsclk);
    rst = 1'b0;
    cyc("s5_single_fast", 1, 1, 1, 1, 0, S_LS, 1, 2'b00, 0);
    idle_chk("s5_no_switch", S_LS, 0, 2'b00, 0);

    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hsclk_sel_fsm.md
HSCLK_SEL_FSM -- requirements
Module: hsclk_sel_fsm

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop stages on each asynchronous ack input, legal range 2..4.
REQ-002 Parameter HOLD_CYCLES, default 8: minimum hsclk cycles spent in HS before a drop to LS is permitted, legal range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: hsclk cycles to wait for an ack before a switch is abandoned, legal range 4..1023.
REQ-004 Parameter DIV_W, default 2: width of the CPU clock divider select.
REQ-005 hsclk  in  1  the single clock; all flops are rising-edge on hsclk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 cyc_valid  in  1  one-hsclk-cycle strobe marking one completed CPU bus cycle; vpa, vda, himem and vram_wr are sampled only when cyc_valid=1.
REQ-008 vpa, vda  in  1 each  CPU cycle-type qualifiers for the cycle marked by cyc_valid.
REQ-009 himem  in  1  the marked cycle addresses on-board memory.
REQ-010 vram_wr  in  1  the marked cycle is a write to video RAM.
REQ-011 hs_en  in  1  high-speed clock enable from the map register.
REQ-012 div_wr  in  1  write strobe for the divider select.
REQ-013 div_in  in  DIV_W  new divider select value.
REQ-014 hs_ack, ls_ack  in  1 each  asynchronous completion acks from the clock multiplexer.
REQ-015 hs_req, ls_req  out  1 each  level switch requests to the clock multiplexer.
REQ-016 hs_selected  out  1  CPU is running on hsclk.
REQ-017 dummy_access  out  1  the BBC-side bus cycle is forced to a dummy read.
REQ-018 div_sel  out  DIV_W  registered divider select.
REQ-019 sw_err  out  1  sticky flag: a switch timed out.

Function
REQ-020 The state machine SHALL have four states, one-hot or binary: LS, TO_HS, HS, TO_LS.
REQ-021 A fast cycle SHALL be defined as cyc_valid & vpa & vda & himem & !vram_wr.
REQ-022 The block SHALL hold a one-bit prev_sync flop, updated only on cycles where cyc_valid & vpa & vda, taking the fast-cycle value.
REQ-023 LS -> TO_HS SHALL occur when hs_en & fast cycle & prev_sync, i.e. on two consecutive opcode fetches from himem.
REQ-024 TO_HS -> HS SHALL occur on the synchronised hs_ack.
REQ-025 TO_HS -> LS SHALL occur when the timeout counter reaches TIMEOUT_CYCLES-1 with no ack; this sets sw_err.
REQ-026 If hs_ack and the timeout coincide in the same cycle, the ack SHALL win: go to HS and do not set sw_err.
REQ-027 Entry to HS SHALL load the hold counter with HOLD_CYCLES-1; the counter then decrements each cycle and saturates at 0.
REQ-028 HS -> TO_LS SHALL occur when hs_en=0 (immediately, regardless of the hold counter).
REQ-029 HS -> TO_LS SHALL also occur when cyc_valid & (vpa|vda) & (!himem | vram_wr) and the hold counter=0.
REQ-030 In HS, cycles with vpa=vda=0 SHALL never cause a drop.
REQ-031 TO_LS -> LS SHALL occur on the synchronised ls_ack.
REQ-032 On a TO_LS timeout, the block SHALL set sw_err and go to LS anyway.
REQ-033 hs_req SHALL be 1 in TO_HS and HS; ls_req SHALL be 1 in TO_LS and LS.
REQ-034 All outputs SHALL be registered.
REQ-035 hs_selected SHALL be 1 only in HS.
REQ-036 dummy_access SHALL equal (state!=LS) | (himem & cyc_valid) registered, so it is valid one cycle after the qualifying cycle.
REQ-037 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide, clear on every state entry, and count only in TO_HS/TO_LS.
REQ-038 div_sel SHALL load div_in on div_wr only while in LS; writes in any other state SHALL be dropped.
REQ-039 If div_wr coincides with LS->TO_HS, the write SHALL still be taken.
REQ-040 sw_err SHALL be cleared only by rst.
REQ-041 Ack synchronisers SHALL be exactly SYNC_STAGES flops; latency from an ack edge to the state change is SYNC_STAGES+1 hsclk cycles.

Reset
REQ-042 While rst=1, and asynchronously on its assertion (including mid-switch), the block SHALL force: state=LS, ls_req=1, hs_req=0, hs_selected=0, dummy_access=0, div_sel=0, sw_err=0, prev_sync=0, all counters 0, synchronisers 0.
REQ-043 The first state transition after rst deasserts SHALL be possible on the first rising edge of hsclk.

Verification
REQ-044 Scenario 1: hs_en=1, two consecutive fast cycles, hs_ack raised -> hs_req rises the cycle after the 2nd fast cycle; hs_selected=1 exactly SYNC_STAGES+1 cycles after hs_ack.
REQ-045 Scenario 2: in HS with HOLD_CYCLES=8, a non-himem data cycle at dwell cycle 3 -> no drop; a repeat at dwell cycle 9 -> TO_LS, then LS after ls_ack.
REQ-046 Scenario 3: hs_ack held 0 -> after 64 cycles state=LS and sw_err=1; a later hs_ack arriving with the timeout in the same cycle -> HS and sw_err stays 1 from before.
REQ-047 Scenario 4: div_wr with div_in=2'b11 in HS -> div_sel unchanged; the same write in LS -> div_sel=2'b11 next cycle.
REQ-048 Scenario 5: rst pulsed while in TO_HS -> all outputs at reset values within the same cycle; a single fast cycle afterwards does not start a switch.
REQ-049 Scenario 6: in HS, a vram_wr cycle with hold expired -> TO_LS; hs_en dropped during the hold period -> TO_LS next cycle.
